// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared state encoding and sizing constants for the LUT configuration loader
package lut_cfg_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, RESP} state_t;
  localparam int LUT_BITS = 16;
  localparam int LUT_ADDR_WIDTH = 4;
  localparam int LOAD_LATENCY = 33;
endpackage

// File: rtl/lut_we_decoder.sv
// lut_we_decoder: binary LUT id to one-hot write enable, all-zero when disabled
module lut_we_decoder #(
  parameter int NUM_LUTS = 32,
  parameter int ID_WIDTH = 6
) (
  input  logic                en,
  input  logic [ID_WIDTH-1:0] id,
  output logic [NUM_LUTS-1:0] we
);
  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_we
    assign we[i] = en && id == ID_WIDTH'(i);
  end
endmodule

// File: rtl/lut_config_loader.sv
// lut_config_loader: serially writes a 16-bit INIT into one LUT of a bank, reads it back,
// and reports a one-cycle response flagging bad ids or readback mismatches.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 32,
  parameter int ID_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ID_WIDTH-1:0]       cfg_lut_id,
  input  logic [LUT_BITS-1:0]       cfg_init,
  output logic [NUM_LUTS-1:0]       lut_we,
  output logic [LUT_ADDR_WIDTH-1:0] lut_addr,
  output logic                      lut_d,
  input  logic [NUM_LUTS-1:0]       lut_o,
  output logic                      cfg_active,
  output logic                      resp_valid,
  output logic                      resp_error
);
  localparam logic [ID_WIDTH:0] LUT_COUNT = (ID_WIDTH + 1)'(NUM_LUTS);
  state_t state, state_n;
  logic [ID_WIDTH-1:0] id;
  logic [LUT_BITS-1:0] init;
  logic [LUT_ADDR_WIDTH-1:0] cnt;
  logic [NUM_LUTS-1:0] lut_sh;
  logic err, bad, last, take;
  assign bad = {1'b0, cfg_lut_id} >= LUT_COUNT;
  assign last = &cnt;
  assign take = cfg_valid && cfg_ready;
  // shift instead of a direct index keeps the select width-clean for any NUM_LUTS
  assign lut_sh = lut_o >> id;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      id <= '0;
      init <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        id <= cfg_lut_id;
        init <= cfg_init;
        cnt <= '0;
        err <= bad;
      end else if (cfg_active) cnt <= cnt + 1'b1;
      if (state == VERIFY && lut_sh[0] != init[cnt]) err <= 1'b1;
    end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   state_n = cfg_valid ? (bad ? RESP : WRITE) : IDLE;
      WRITE:  state_n = last ? VERIFY : WRITE;
      VERIFY: state_n = last ? RESP : VERIFY;
      RESP:   state_n = IDLE;
    endcase
    cfg_ready = state == IDLE && !reset;
    cfg_active = state == WRITE || state == VERIFY;
    lut_addr = cfg_active ? cnt : '0;
    lut_d = state == WRITE && init[cnt];
    resp_valid = state == RESP;
    resp_error = resp_valid && err;
  end
  lut_we_decoder #(.NUM_LUTS(NUM_LUTS), .ID_WIDTH(ID_WIDTH)) u_dec (
    .en(state == WRITE),
    .id(id),
    .we(lut_we)
  );
endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader: directed and randomized loads against a behavioural LUT bank
// with optional stuck-at-0 bit and a spec-level response/timing model.
module tb_lut_config_loader;
  import lut_cfg_pkg::*;
  localparam int NL = 32;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [5:0] cfg_lut_id = '0;
  logic [15:0] cfg_init = '0;
  logic [NL-1:0] lut_we, lut_o;
  logic [3:0] lut_addr;
  logic lut_d, cfg_active, resp_valid, resp_error;
  logic [15:0] bank [NL];
  logic fault_en = 1'b0;
  int fault_lut = 0;
  int fault_bit = 0;
  int total = 0;
  int bad = 0;
  lut_config_loader #(.NUM_LUTS(NL), .ID_WIDTH(6)) dut (
    .clock(clock),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_lut_id(cfg_lut_id),
    .cfg_init(cfg_init),
    .lut_we(lut_we),
    .lut_addr(lut_addr),
    .lut_d(lut_d),
    .lut_o(lut_o),
    .cfg_active(cfg_active),
    .resp_valid(resp_valid),
    .resp_error(resp_error)
  );
  always #5 clock = ~clock;
  always @(posedge clock)
    for (int k = 0; k < NL; k++) if (lut_we[k]) bank[k][lut_addr] <= lut_d;
  always_comb
    for (int k = 0; k < NL; k++)
      lut_o[k] = bank[k][lut_addr] && !(fault_en && k == fault_lut && int'(lut_addr) == fault_bit);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // caller sits on a negedge; returns on the negedge of the response cycle
  task automatic load(input logic [5:0] id, input logic [15:0] init, input bit chaos, input bit hold, input bit b2b);
    int waited;
    int n;
    bit good;
    bit exp_err;
    logic [NL-1:0] one;
    logic [NL-1:0] oh;
    waited = 0;
    good = int'(id) < NL;
    n = good ? LOAD_LATENCY : 1;
    exp_err = !good || (fault_en && int'(id) == fault_lut && init[fault_bit[3:0]]);
    one = 1;
    oh = one << id;
    cfg_valid = 1'b1;
    cfg_lut_id = id;
    cfg_init = init;
    while (!cfg_ready && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    check("handshake_ready", cfg_ready, 1);
    if (b2b) check("b2b_wait", waited, 1);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      check("we", lut_we, (good && k <= 16) ? oh : '0);
      check("active", cfg_active, good && k <= 32);
      check("addr", lut_addr, (!good || k > 32) ? 0 : (k <= 16 ? k - 1 : k - 17));
      check("d", lut_d, good && k <= 16 && init[4'(k - 1)]);
      check("ready_busy", cfg_ready, 0);
      check("resp_valid", resp_valid, k == n);
      if (k == n) check("resp_error", resp_error, exp_err);
      if (chaos) begin
        cfg_lut_id = 6'($urandom);
        cfg_init = 16'($urandom);
      end
      if (!hold) cfg_valid = 1'b0;
    end
    if (good) check("bank", bank[int'(id)], init);
  endtask
  initial begin
    int w;
    logic seen;
    logic [5:0] rid;
    repeat (3) @(negedge clock);
    check("rst_ready", cfg_ready, 0);
    check("rst_we", lut_we, 0);
    check("rst_active", cfg_active, 0);
    check("rst_resp", resp_valid, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", cfg_ready, 1);
    @(negedge clock);
    load(6'd3, 16'h8000, 0, 0, 0);
    for (int i = 0; i < 16; i++) check("lut3_eval", bank[3][i], i == 15);
    @(negedge clock);
    load(6'd40, 16'h1234, 0, 0, 0);
    @(negedge clock);
    check("bad_ready_t2", cfg_ready, 1);
    fault_en = 1'b1;
    fault_lut = 5;
    fault_bit = 7;
    load(6'd5, 16'hFFFF, 0, 0, 0);
    fault_en = 1'b0;
    @(negedge clock);
    load(6'd0, 16'hAAAA, 0, 1, 0);
    load(6'd31, 16'h5555, 0, 0, 1);
    check("b2b_lut0", bank[0], 16'hAAAA);
    @(negedge clock);
    cfg_valid = 1'b1;
    cfg_lut_id = 6'd2;
    cfg_init = 16'hFFFF;
    w = 0;
    while (!cfg_ready && w < 64) begin
      @(negedge clock);
      w++;
    end
    check("rst_load_ready", cfg_ready, 1);
    repeat (9) @(negedge clock);
    cfg_valid = 1'b0;
    check("pre_rst_we", lut_we, 32'h4);
    #1 reset = 1'b1;
    #1;
    check("async_we", lut_we, 0);
    check("async_active", cfg_active, 0);
    check("async_addr", lut_addr, 0);
    check("async_d", lut_d, 0);
    check("async_ready", cfg_ready, 0);
    check("async_resp", {resp_valid, resp_error}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen = seen | resp_valid;
    end
    check("no_resp_after_rst", seen, 0);
    load(6'd2, 16'h0F0F, 0, 0, 0);
    @(negedge clock);
    load(6'd1, 16'h1234, 1, 0, 0);
    repeat (10) begin
      @(negedge clock);
      rid = 6'($urandom_range(0, 47));
      fault_en = $urandom_range(0, 2) == 0;
      fault_lut = $urandom_range(0, 1) == 0 ? int'(rid) : $urandom_range(0, NL - 1);
      fault_bit = $urandom_range(0, 15);
      load(rid, 16'($urandom), $urandom_range(0, 1) == 1, 0, 0);
      fault_en = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
